// File: rtl/snake_cpu_cpu_mult_combine.sv
// Combines the four 16x16 partial products of a 32x32 multiply into the 64-bit product and returns one word.
// Latency PIPE_STAGES cycles (1: single add stage, 2: middle-sum stage + final-sum stage), throughput 1/cycle.
// Valid/ready backpressure: each stage holds while its successor is stalled; outputs stable while out_ready=0.
// Optional: define SNAKE_MUL_COMBINE_FULL64_EN to expose the full product on out_result64.
module snake_cpu_cpu_mult_combine #(
  parameter int TAG_W       = 5,
  parameter int PIPE_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_p1,
  input  logic [31:0]      in_p2,
  input  logic [31:0]      in_p3,
  input  logic [31:0]      in_p4,
  input  logic             in_src1_signed,
  input  logic             in_src2_signed,
  input  logic             in_hi,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag
`ifdef SNAKE_MUL_COMBINE_FULL64_EN
  ,
  output logic [63:0]      out_result64
`endif
);

  // Cross products are 33-bit signed quantities; their sum always fits in 34 bits.
  logic [33:0] x2, x3, mid;
  logic [63:0] mid64, lo_d;

  // Fold the cross-product sum onto p1; result is the product minus the p4 contribution.
  always_comb begin
    x2    = {{2{in_src2_signed & in_p2[31]}}, in_p2};
    x3    = {{2{in_src1_signed & in_p3[31]}}, in_p3};
    mid   = x2 + x3;
    mid64 = {{30{mid[33]}}, mid};
    lo_d  = {32'h0, in_p1} + (mid64 << 16);
  end

  // Signals feeding the final stage, either straight from the inputs or from the middle register.
  logic             fin_vld;
  logic [63:0]      fin_lo;
  logic [31:0]      fin_p4;
  logic             fin_hi;
  logic [TAG_W-1:0] fin_tag;

  logic out_vld_q;
  logic last_adv;

  assign last_adv = ~out_vld_q | out_ready;

  generate
    if (PIPE_STAGES == 1) begin : g_one
      assign in_ready = last_adv;
      assign fin_vld  = in_valid;
      assign fin_lo   = lo_d;
      assign fin_p4   = in_p4;
      assign fin_hi   = in_hi;
      assign fin_tag  = in_tag;
    end else begin : g_two
      logic             s1_vld_q;
      logic [63:0]      s1_lo_q;
      logic [31:0]      s1_p4_q;
      logic             s1_hi_q;
      logic [TAG_W-1:0] s1_tag_q;
      logic             s1_adv;

      assign s1_adv   = ~s1_vld_q | last_adv;
      assign in_ready = s1_adv;

      // Middle-stage occupancy: refilled (or emptied) whenever the stage may move.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_vld_q <= 1'b0;
        end else if (s1_adv) begin
          s1_vld_q <= in_valid;
        end
      end

      // Middle-stage data loads only with a real op, so idle garbage never enters the pipe.
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          s1_lo_q  <= '0;
          s1_p4_q  <= '0;
          s1_hi_q  <= 1'b0;
          s1_tag_q <= '0;
        end else if (s1_adv & in_valid) begin
          s1_lo_q  <= lo_d;
          s1_p4_q  <= in_p4;
          s1_hi_q  <= in_hi;
          s1_tag_q <= in_tag;
        end
      end

      assign fin_vld = s1_vld_q;
      assign fin_lo  = s1_lo_q;
      assign fin_p4  = s1_p4_q;
      assign fin_hi  = s1_hi_q;
      assign fin_tag = s1_tag_q;
    end
  endgenerate

  logic [63:0]      prod_d;
  logic [31:0]      res_d, res_q;
  logic [TAG_W-1:0] tag_q;

  // Final sum adds p4 into the upper word, then picks the requested half.
  always_comb begin
    prod_d = fin_lo + {fin_p4, 32'h0};
    res_d  = fin_hi ? prod_d[63:32] : prod_d[31:0];
  end

  // Output occupancy: refilled whenever the consumer takes the current result or none is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q <= 1'b0;
    end else if (last_adv) begin
      out_vld_q <= fin_vld;
    end
  end

  // Output word and tag, held while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res_q <= '0;
      tag_q <= '0;
    end else if (last_adv & fin_vld) begin
      res_q <= res_d;
      tag_q <= fin_tag;
    end
  end

`ifdef SNAKE_MUL_COMBINE_FULL64_EN
  logic [63:0] res64_q;

  // Full product travels with the selected word under the same load/hold rules.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      res64_q <= '0;
    end else if (last_adv & fin_vld) begin
      res64_q <= prod_d;
    end
  end

  assign out_result64 = out_vld_q ? res64_q : '0;
`endif

  // Data outputs read as zero whenever no result is presented.
  assign out_valid  = out_vld_q;
  assign out_result = out_vld_q ? res_q : '0;
  assign out_tag    = out_vld_q ? tag_q : '0;

endmodule

// File: tb/tb_snake_cpu_cpu_mult_combine.sv
// Bench for snake_cpu_cpu_mult_combine: vector table plus directed sequences, scoreboard-checked.
module tb_snake_cpu_cpu_mult_combine;
  localparam int TAG_W = 5;
  localparam int PS    = 2;

  logic             clk;
  logic             reset;
  logic             in_valid, in_ready;
  logic [31:0]      in_p1, in_p2, in_p3, in_p4;
  logic             in_src1_signed, in_src2_signed, in_hi;
  logic [TAG_W-1:0] in_tag;
  logic             out_valid, out_ready;
  logic [31:0]      out_result;
  logic [TAG_W-1:0] out_tag;
`ifdef SNAKE_MUL_COMBINE_FULL64_EN
  logic [63:0]      out_result64;
`endif

  snake_cpu_cpu_mult_combine #(.TAG_W(TAG_W), .PIPE_STAGES(PS)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_p1(in_p1), .in_p2(in_p2), .in_p3(in_p3), .in_p4(in_p4),
    .in_src1_signed(in_src1_signed), .in_src2_signed(in_src2_signed),
    .in_hi(in_hi), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
`ifdef SNAKE_MUL_COMBINE_FULL64_EN
    , .out_result64(out_result64)
`endif
  );

  typedef struct {
    logic [31:0] p1, p2, p3, p4;
    logic        s1, s2, hi;
    logic [31:0] exp;
    logic [63:0] exp64;
  } vec_t;

  typedef struct {
    logic [31:0]      res;
    logic [63:0]      p;
    logic [TAG_W-1:0] tag;
  } sb_t;

  sb_t  sb[$];
  int   pop_cyc[$];
  vec_t vt[12];
  vec_t rv[8];
  int   npass = 0;
  int   ntotal = 0;
  int   cyc = 0;
  int   nacc = 0;
  int   npop = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    ntotal++;
    if (act === exp) npass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: build partial products from real operands, expected value from a full 64-bit multiply.
  function automatic vec_t mk_op(input logic [31:0] a, input logic [31:0] b,
                                 input logic sa, input logic sb_, input logic hi);
    vec_t v;
    logic [63:0] al, ah, bl, bh, t, aa, bb;
    al = {48'h0, a[15:0]};
    bl = {48'h0, b[15:0]};
    ah = sa  ? {{48{a[31]}}, a[31:16]} : {48'h0, a[31:16]};
    bh = sb_ ? {{48{b[31]}}, b[31:16]} : {48'h0, b[31:16]};
    t = al * bl; v.p1 = t[31:0];
    t = al * bh; v.p2 = t[31:0];
    t = ah * bl; v.p3 = t[31:0];
    t = ah * bh; v.p4 = t[31:0];
    aa = sa  ? {{32{a[31]}}, a} : {32'h0, a};
    bb = sb_ ? {{32{b[31]}}, b} : {32'h0, b};
    t = aa * bb;
    v.s1 = sa; v.s2 = sb_; v.hi = hi;
    v.exp64 = t;
    v.exp = hi ? t[63:32] : t[31:0];
    return v;
  endfunction

  function automatic vec_t mk_pp(input logic [31:0] p1, input logic [31:0] p2, input logic [31:0] p3,
                                 input logic [31:0] p4, input logic s, input logic hi,
                                 input logic [31:0] exp, input logic [63:0] exp64);
    vec_t v;
    v.p1 = p1; v.p2 = p2; v.p3 = p3; v.p4 = p4;
    v.s1 = s; v.s2 = s; v.hi = hi; v.exp = exp; v.exp64 = exp64;
    return v;
  endfunction

  task automatic idle();
    in_valid = 1'b0;
    in_p1 = 'x; in_p2 = 'x; in_p3 = 'x; in_p4 = 'x;
    in_hi = 'x; in_tag = 'x;
    in_src1_signed = 'x; in_src2_signed = 'x;
  endtask

  // Offer one op; called just after a rising edge, returns just after the edge that took it.
  task automatic send(input vec_t v, input logic [TAG_W-1:0] tag);
    int  w;
    sb_t e;
    w = 0;
    in_valid = 1'b1;
    in_p1 = v.p1; in_p2 = v.p2; in_p3 = v.p3; in_p4 = v.p4;
    in_src1_signed = v.s1; in_src2_signed = v.s2; in_hi = v.hi; in_tag = tag;
    while (1) begin
      @(negedge clk);
      if (in_ready) begin
        e.res = v.exp; e.p = v.exp64; e.tag = tag;
        sb.push_back(e);
        nacc++;
        @(posedge clk); #1;
        break;
      end
      @(posedge clk); #1;
      w++;
      if (w > 200) begin
        chk("send_timeout_in_ready", in_ready, 1);
        break;
      end
    end
  endtask

  task automatic wait_drain();
    int w;
    w = 0;
    while ((sb.size() != 0 || out_valid) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("drain_scoreboard_empty", sb.size(), 0);
    chk("idle_out_result_zero", out_result, 0);
    chk("idle_out_tag_zero", out_tag, 0);
  endtask

  // Monitor: pop the scoreboard on each handshake and check that stalled outputs stay put.
  initial begin
    bit               prev_stall;
    logic [31:0]      prev_res;
    logic [TAG_W-1:0] prev_tag;
    sb_t              e;
    prev_stall = 0;
    prev_res = '0;
    prev_tag = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_out_valid", out_valid, 1);
          chk("stall_out_result", out_result, prev_res);
          chk("stall_out_tag", out_tag, prev_tag);
        end
        if (out_valid && out_ready) begin
          if (sb.size() == 0) begin
            chk("unexpected_output_valid", out_valid, 0);
          end else begin
            e = sb.pop_front();
            chk("out_result", out_result, e.res);
            chk("out_tag", out_tag, e.tag);
`ifdef SNAKE_MUL_COMBINE_FULL64_EN
            chk("out_result64", out_result64, e.p);
`endif
            npop++;
            pop_cyc.push_back(cyc);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_res = out_result;
        prev_tag = out_tag;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    vt[0]  = mk_pp(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b0, 1'b0,
                   32'h00000001, 64'hFFFFFFFE_00000001);
    vt[1]  = mk_pp(32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 32'hFFFE0001, 1'b0, 1'b1,
                   32'hFFFFFFFE, 64'hFFFFFFFE_00000001);
    vt[2]  = mk_pp(32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 1'b1, 1'b0,
                   32'h00000001, 64'h00000000_00000001);
    vt[3]  = mk_pp(32'hFFFE0001, 32'hFFFF0001, 32'hFFFF0001, 32'h00000001, 1'b1, 1'b1,
                   32'h00000000, 64'h00000000_00000001);
    vt[4]  = mk_pp(32'h0002FFFA, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b1, 1'b0,
                   32'hFFFFFFFA, 64'hFFFFFFFF_FFFFFFFA);
    vt[5]  = mk_pp(32'h0002FFFA, 32'hFFFFFFFD, 32'h0, 32'h0, 1'b1, 1'b1,
                   32'hFFFFFFFF, 64'hFFFFFFFF_FFFFFFFA);
    vt[6]  = mk_op(32'h12345678, 32'h9ABCDEF0, 1'b0, 1'b0, 1'b1);
    vt[7]  = mk_op(32'h80000000, 32'h80000000, 1'b1, 1'b1, 1'b1);
    vt[8]  = mk_op(32'hFFFFFFFF, 32'h00000002, 1'b1, 1'b0, 1'b1);
    vt[9]  = mk_op(32'h7FFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b1, 1'b0);
    vt[10] = mk_op(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b1);
    vt[11] = mk_op(32'h00000000, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0);
    for (int k = 0; k < 8; k++)
      rv[k] = mk_op($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)));

    // Reset state
    reset = 1'b1;
    out_ready = 1'b1;
    idle();
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_out_result", out_result, 0);
    chk("reset_out_tag", out_tag, 0);
    chk("reset_in_ready", in_ready, 1);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // Vector table, back to back
    npop = 0;
    for (int i = 0; i < 12; i++) send(vt[i], TAG_W'(i));
    idle();
    wait_drain();
    chk("table_result_count", npop, 12);

    // Eight ops back to back: first result PS cycles after launch, then one per cycle
    npop = 0;
    pop_cyc.delete();
    c0 = cyc;
    for (int k = 0; k < 8; k++) send(rv[k], TAG_W'(k));
    idle();
    wait_drain();
    chk("b2b_result_count", npop, 8);
    if (pop_cyc.size() == 8) begin
      chk("b2b_first_latency", pop_cyc[0] - c0, PS);
      for (int k = 1; k < 8; k++) chk("b2b_spacing", pop_cyc[k] - pop_cyc[k-1], 1);
    end

    // Stall: three ops offered while the consumer refuses for five cycles
    npop = 0;
    nacc = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int k = 0; k < 3; k++) send(vt[6+k], TAG_W'(8 + k));
        idle();
      end
      begin
        repeat (5) @(posedge clk);
        #1;
        chk("stall_accept_count", nacc, PS);
        chk("stall_in_ready_low", in_ready, 0);
        chk("stall_out_valid_held", out_valid, 1);
        out_ready = 1'b1;
      end
    join
    wait_drain();
    chk("stall_result_count", npop, 3);

    // Asynchronous reset with two ops in flight
    out_ready = 1'b0;
    send(vt[0], 5'd20);
    send(vt[1], 5'd21);
    idle();
    @(posedge clk); #1;
    chk("inflight_out_valid", out_valid, 1);
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset_out_valid", out_valid, 0);
    chk("async_reset_out_result", out_result, 0);
    chk("async_reset_out_tag", out_tag, 0);
    chk("async_reset_in_ready", in_ready, 1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    chk("held_reset_in_ready", in_ready, 1);
    reset = 1'b0;
    out_ready = 1'b1;
    npop = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("post_reset_no_stale", out_valid, 0);
    send(vt[4], 5'd22);
    idle();
    wait_drain();
    chk("post_reset_result_count", npop, 1);

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
